// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared defaults and state encoding for the EX/MEM skid buffer
package ex_mem_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;
endpackage

// File: rtl/ex_mem_entry.sv
// ex_mem_entry: one valid+payload register with load and clear
// Ports: clk, rst (async active-low), clr (invalidate and zero), ld (capture d_*),
//        d_* payload in, valid/q_* registered entry out. clr wins over ld.
module ex_mem_entry
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld,
    input  logic [ADDR_W-1:0] d_wd,
    input  logic              d_wreg,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              valid,
    output logic [ADDR_W-1:0] q_wd,
    output logic              q_wreg,
    output logic [DATA_W-1:0] q_wdata
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            q_wd    <= '0;
            q_wreg  <= 1'b0;
            q_wdata <= '0;
        end else if (clr) begin
            valid   <= 1'b0;
            q_wd    <= '0;
            q_wreg  <= 1'b0;
            q_wdata <= '0;
        end else if (ld) begin
            valid   <= 1'b1;
            q_wd    <= d_wd;
            q_wreg  <= d_wreg;
            q_wdata <= d_wdata;
        end
    end
endmodule

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register built as a two-entry skid buffer
// Ports: clk, rst (async active-low), flush_i (sync discard),
//        ex_valid_i/ex_ready_o + ex_wd_i/ex_wreg_i/ex_wdata_i from execute,
//        mem_valid_o/mem_ready_i + mem_wd_o/mem_wreg_o/mem_wdata_o to memory.
//        ex_ready_o is the inverted skid valid flop, so it never sees mem_ready_i.
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [ADDR_W-1:0] ex_wd_i,
    input  logic              ex_wreg_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_wd_o,
    output logic              mem_wreg_o,
    output logic [DATA_W-1:0] mem_wdata_o
);
    state_t            state, nxt;
    logic              acc, rel;
    logic              m_ld, m_clr, s_ld, s_clr, m_from_skid;
    logic              m_valid, s_valid;
    logic [ADDR_W-1:0] m_wd, s_wd, m_d_wd;
    logic              m_wreg, s_wreg, m_d_wreg;
    logic [DATA_W-1:0] m_wdata, s_wdata, m_d_wdata;

    assign acc = ex_valid_i & ex_ready_o;
    assign rel = m_valid & mem_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_EMPTY;
        else      state <= nxt;
    end

    always_comb begin
        nxt         = state;
        m_ld        = 1'b0;
        m_clr       = 1'b0;
        s_ld        = 1'b0;
        s_clr       = 1'b0;
        m_from_skid = 1'b0;
        if (flush_i) begin
            nxt   = ST_EMPTY;
            m_clr = 1'b1;
            s_clr = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: if (acc) begin
                    nxt  = ST_ONE;
                    m_ld = 1'b1;
                end
                ST_ONE: if (acc && rel) begin
                    m_ld = 1'b1;
                end else if (acc) begin
                    nxt  = ST_FULL;
                    s_ld = 1'b1;
                end else if (rel) begin
                    nxt   = ST_EMPTY;
                    m_clr = 1'b1;
                end
                ST_FULL: if (rel) begin
                    nxt         = ST_ONE;
                    m_ld        = 1'b1;
                    m_from_skid = 1'b1;
                    s_clr       = 1'b1;
                end
                default: begin
                    nxt   = ST_EMPTY;
                    m_clr = 1'b1;
                    s_clr = 1'b1;
                end
            endcase
        end
    end

    assign m_d_wd    = m_from_skid ? s_wd    : ex_wd_i;
    assign m_d_wreg  = m_from_skid ? s_wreg  : ex_wreg_i;
    assign m_d_wdata = m_from_skid ? s_wdata : ex_wdata_i;

    ex_mem_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_main (
        .clk(clk), .rst(rst), .clr(m_clr), .ld(m_ld),
        .d_wd(m_d_wd), .d_wreg(m_d_wreg), .d_wdata(m_d_wdata),
        .valid(m_valid), .q_wd(m_wd), .q_wreg(m_wreg), .q_wdata(m_wdata)
    );

    ex_mem_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
        .clk(clk), .rst(rst), .clr(s_clr), .ld(s_ld),
        .d_wd(ex_wd_i), .d_wreg(ex_wreg_i), .d_wdata(ex_wdata_i),
        .valid(s_valid), .q_wd(s_wd), .q_wreg(s_wreg), .q_wdata(s_wdata)
    );

    assign ex_ready_o  = ~s_valid;
    assign mem_valid_o = m_valid;
    assign mem_wd_o    = m_valid ? m_wd    : '0;
    assign mem_wreg_o  = m_valid & m_wreg;
    assign mem_wdata_o = m_valid ? m_wdata : '0;
endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: directed table plus randomized queue-model check of ex_mem
module tb_ex_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        vin = 1'b0;
    logic        ready;
    logic [4:0]  wd = '0;
    logic        wreg = 1'b0;
    logic [31:0] wdata = '0;
    logic        mvalid;
    logic        mready = 1'b0;
    logic [4:0]  mwd;
    logic        mwreg;
    logic [31:0] mwdata;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        logic        flush, vin;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        mready;
        logic        ev, er;
        logic [4:0]  ewd;
        logic        ewreg;
        logic [31:0] edata;
    } vec_t;
    vec_t tbl[17];

    ex_mem dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .ex_valid_i(vin), .ex_ready_o(ready),
        .ex_wd_i(wd), .ex_wreg_i(wreg), .ex_wdata_i(wdata),
        .mem_valid_o(mvalid), .mem_ready_i(mready),
        .mem_wd_o(mwd), .mem_wreg_o(mwreg), .mem_wdata_o(mwdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two results; ready means fewer than two held.
    task automatic step();
        bit acc, rel;
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            acc = vin && mq.size() < 2;
            rel = mq.size() > 0 && mready;
            if (rel) void'(mq.pop_front());
            if (acc) mq.push_back('{wd, wreg, wdata});
        end
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        ent_t e;
        e = mq.size() > 0 ? mq[0] : '{5'd0, 1'b0, 32'd0};
        chk({tag, ".valid"}, 32'(mvalid), 32'(mq.size() > 0));
        chk({tag, ".ready"}, 32'(ready), 32'(mq.size() < 2));
        chk({tag, ".wd"}, 32'(mwd), 32'(e.wd));
        chk({tag, ".wreg"}, 32'(mwreg), 32'(e.wreg));
        chk({tag, ".wdata"}, mwdata, e.wdata);
    endtask

    task automatic drive(input logic f, input logic v, input logic [4:0] a, input logic w,
                         input logic [31:0] d, input logic r);
        flush = f; vin = v; wd = a; wreg = w; wdata = d; mready = r;
    endtask

    initial begin
        //          flush vin wd  wreg wdata          mrdy  ev er  ewd wreg edata
        tbl[0]  = '{0, 1, 5'd3, 1, 32'h0000_00FF, 1,   1, 1, 5'd3, 1, 32'h0000_00FF};
        tbl[1]  = '{0, 1, 5'd4, 1, 32'h1234_5678, 1,   1, 1, 5'd4, 1, 32'h1234_5678};
        tbl[2]  = '{0, 0, 5'd0, 0, 32'h0,         1,   0, 1, 5'd0, 0, 32'h0};
        tbl[3]  = '{0, 1, 5'd1, 1, 32'h11,        0,   1, 1, 5'd1, 1, 32'h11};
        tbl[4]  = '{0, 1, 5'd2, 0, 32'h22,        0,   1, 0, 5'd1, 1, 32'h11};
        tbl[5]  = '{0, 1, 5'd9, 1, 32'h99,        0,   1, 0, 5'd1, 1, 32'h11};
        tbl[6]  = '{0, 0, 5'd0, 0, 32'h0,         1,   1, 1, 5'd2, 0, 32'h22};
        tbl[7]  = '{0, 0, 5'd0, 0, 32'h0,         1,   0, 1, 5'd0, 0, 32'h0};
        tbl[8]  = '{0, 1, 5'd5, 1, 32'h55,        0,   1, 1, 5'd5, 1, 32'h55};
        tbl[9]  = '{0, 1, 5'd6, 1, 32'h66,        0,   1, 0, 5'd5, 1, 32'h55};
        tbl[10] = '{1, 1, 5'd7, 1, 32'h77,        0,   0, 1, 5'd0, 0, 32'h0};
        tbl[11] = '{0, 0, 5'd0, 0, 32'h0,         1,   0, 1, 5'd0, 0, 32'h0};
        tbl[12] = '{0, 0, 5'd31, 1, 32'hDEAD,     0,   0, 1, 5'd0, 0, 32'h0};
        tbl[13] = '{1, 1, 5'd10, 1, 32'hAA,       1,   0, 1, 5'd0, 0, 32'h0};
        tbl[14] = '{0, 1, 5'd8, 1, 32'h88,        0,   1, 1, 5'd8, 1, 32'h88};
        tbl[15] = '{0, 0, 5'd0, 0, 32'h0,         0,   1, 1, 5'd8, 1, 32'h88};
        tbl[16] = '{1, 0, 5'd0, 0, 32'h0,         0,   0, 1, 5'd0, 0, 32'h0};

        drive(0, 1, 5'd7, 1, 32'hCAFE_F00D, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", 32'(mvalid), 32'd0);
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.wd", 32'(mwd), 32'd0);
        chk("rst.wreg", 32'(mwreg), 32'd0);
        chk("rst.wdata", mwdata, 32'd0);
        rst = 1'b1;
        drive(0, 0, 5'd0, 0, 32'd0, 0);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].flush, tbl[i].vin, tbl[i].wd, tbl[i].wreg, tbl[i].wdata, tbl[i].mready);
            step();
            chk($sformatf("vec%0d.valid", i), 32'(mvalid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d.ready", i), 32'(ready), 32'(tbl[i].er));
            chk($sformatf("vec%0d.wd", i), 32'(mwd), 32'(tbl[i].ewd));
            chk($sformatf("vec%0d.wreg", i), 32'(mwreg), 32'(tbl[i].ewreg));
            chk($sformatf("vec%0d.wdata", i), mwdata, tbl[i].edata);
        end

        drive(0, 1, 5'd12, 1, 32'hA1A1_A1A1, 0);
        step();
        drive(0, 1, 5'd13, 1, 32'hB2B2_B2B2, 0);
        step();
        chk("arst.full_ready", 32'(ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        mq.delete();
        chk("arst.valid", 32'(mvalid), 32'd0);
        chk("arst.ready", 32'(ready), 32'd1);
        chk("arst.wd", 32'(mwd), 32'd0);
        chk("arst.wreg", 32'(mwreg), 32'd0);
        chk("arst.wdata", mwdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 5'd14, 1, 32'hC3C3_C3C3, 1);
        step();
        chk_model("arst.first");
        chk("arst.first_wdata", mwdata, 32'hC3C3_C3C3);
        drive(0, 0, 5'd0, 0, 32'd0, 1);
        step();
        chk_model("arst.nostale");
        chk("arst.nostale_valid", 32'(mvalid), 32'd0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, 5'($urandom), 1'($urandom),
                  $urandom, $urandom_range(0, 9) < 6);
            step();
            chk_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 Parameter: DATA_W, 32, width of result data (RegBus).
REQ-002 Parameter: ADDR_W, 5, width of destination register address (RegAddrBus).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; a low level clears all state immediately, independent of clk.
REQ-005 flush_i  input  1  synchronous discard of all buffered results.
REQ-006 ex_valid_i  input  1  execute stage presents a result this cycle.
REQ-007 ex_ready_o  output  1  block can accept an execute result this cycle.
REQ-008 ex_wd_i  input  ADDR_W  destination register address from execute.
REQ-009 ex_wreg_i  input  1  register-write enable from execute.
REQ-010 ex_wdata_i  input  DATA_W  result data from execute.
REQ-011 mem_valid_o  output  1  memory stage result is present.
REQ-012 mem_ready_i  input  1  memory stage consumes the presented result this cycle.
REQ-013 mem_wd_o  output  ADDR_W  destination address to memory stage.
REQ-014 mem_wreg_o  output  1  write enable to memory stage; forced 0 when mem_valid_o=0.
REQ-015 mem_wdata_o  output  DATA_W  result data to memory stage.

Function
REQ-016 The block SHALL be a two-entry skid buffer: a main entry driving mem_* outputs and one skid entry.
REQ-017 Accept occurs when ex_valid_i=1 and ex_ready_o=1 at a rising edge; release occurs when mem_valid_o=1 and mem_ready_i=1 at a rising edge.
REQ-018 ex_ready_o SHALL be a registered signal equal to NOT skid-entry-valid; it SHALL NOT depend combinationally on mem_ready_i.
REQ-019 Latency: an accepted result SHALL appear on mem_* outputs in the cycle after acceptance when the main entry is empty or being released.
REQ-020 States: EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
REQ-021 EMPTY: accept -> ONE, main loads input; otherwise stay.
REQ-022 ONE: accept and release -> ONE, main loads input; accept only -> FULL, skid loads input; release only -> EMPTY; neither -> ONE unchanged.
REQ-023 FULL: release -> ONE, main loads skid contents; otherwise hold (no accept possible).
REQ-024 Results SHALL leave in acceptance order; no result duplicated or dropped absent flush.
REQ-025 Outputs SHALL remain stable while mem_valid_o=1 and mem_ready_i=0.
REQ-026 flush_i=1 at an edge SHALL force EMPTY, with priority over accept and release; any input accepted in that cycle is discarded.
REQ-027 When mem_valid_o=0, mem_wd_o, mem_wreg_o, mem_wdata_o SHALL be zero.
REQ-028 Data fields pass unmodified; no arithmetic, widths fixed by parameters.

Reset
REQ-029 While rst=0: state EMPTY, mem_valid_o=0, mem_wd_o=0, mem_wreg_o=0, mem_wdata_o=0, ex_ready_o=1, skid entry cleared.
REQ-030 Reset asserted mid-transfer SHALL discard both entries; first accept is permitted on the first rising edge after rst deasserts.

Structure
REQ-031 DATA_W/ADDR_W defaults, state encodings and zero constants SHALL live in the shared defines package.
REQ-032 One sub-module is natural: ex_mem_entry (a single valid+payload register with load/clear), instantiated twice.

Verification
REQ-033 Reset: rst=0 with ex_valid_i=1 -> mem_valid_o=0, all mem_* 0, ex_ready_o=1.
REQ-034 Streaming: mem_ready_i=1, accepts wd=3/wdata=0x0000_00FF then wd=4/wdata=0x1234_5678 on consecutive edges -> same values on mem_* one cycle later each, ex_ready_o stays 1.
REQ-035 Backpressure: mem_ready_i=0, accept A (0x11) and B (0x22) -> FULL, ex_ready_o=0, mem_wdata_o=0x11 held; raise mem_ready_i -> 0x11 then 0x22 released, ex_ready_o=1 after first release.
REQ-036 Flush: in FULL with ex_valid_i=1, flush_i=1 for one edge -> EMPTY next cycle, mem_valid_o=0, input discarded.
REQ-037 Async reset mid-FULL: drop rst between edges -> outputs zero immediately, no stale result after rst release.
REQ-038 Invalid zeroing: ex_wreg_i=1 with ex_valid_i=0 -> mem_wreg_o stays 0.
